// File: rtl/wave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wave_pkg: shared types and constants for the segment sequencer     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package wave_pkg;

   localparam int         SEG_DWELL_W = 16;
   localparam logic [7:0] DUTY_RST    = 8'd128;

   typedef enum logic [1:0] {
      SINE = 2'b00,
      REC  = 2'b01,
      SAW  = 2'b10,
      TRIA = 2'b11
   } wave_sel_e;

   typedef struct packed {
      wave_sel_e               wave_sel;
      logic signed [7:0]       amp;
      logic [7:0]              freq;
      logic [7:0]              duty;
      logic [SEG_DWELL_W-1:0]  dwell;
   } seg_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } seq_state_e;

   // A zero dwell still plays for one cycle.
   function automatic logic [SEG_DWELL_W-1:0] dwell_load(input logic [SEG_DWELL_W-1:0] d);
      return (d == '0) ? '0 : d - SEG_DWELL_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_ram: segment table, one write port, one registered read port   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module seg_ram
   import wave_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  seg_entry_t    wdata,
   input  logic [AW-1:0] raddr,
   output seg_entry_t    rdata
);

   seg_entry_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
      rdata <= r_mem[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/wave_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wave_seq_ctrl: plays a table of waveform segments with dwell times |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module wave_seq_ctrl
   import wave_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int DWELL_W = SEG_DWELL_W,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  seg_entry_t        cfg_wdata,
   input  logic [AW:0]       num_seg,
   input  logic              loop_en,
   input  logic              start,
   input  logic              stop,
   input  logic              hold,
   output logic [1:0]        wave_sel,
   output logic signed [7:0] amp,
   output logic [7:0]        freq,
   output logic [7:0]        duty_cycle,
   output logic [AW-1:0]     seg_idx,
   output logic              busy,
   output logic              seg_start,
   output logic              done,
   output logic              wr_err
);

   seq_state_e         r_state, w_state_nxt;
   logic [AW-1:0]      r_num_m1, w_num_m1;
   logic               r_loop;
   logic [AW-1:0]      r_pf_idx, w_rd_addr, w_pf_wrap;
   logic [AW:0]        w_pf_inc;
   logic [DWELL_W-1:0] r_cnt;
   seg_entry_t         w_rd_data;
   logic               w_wr_ok, w_start_ok, w_stop_ok;
   logic               w_end_seg, w_last, w_apply, w_finish;

   assign w_wr_ok    = cfg_we && !rst && (r_state == IDLE);
   assign w_start_ok = start && !stop && (r_state == IDLE);
   assign w_stop_ok  = stop && (r_state != IDLE);
   assign w_end_seg  = (r_state == RUN) && !hold && (r_cnt == '0);
   assign w_last     = (seg_idx == r_num_m1);
   assign w_finish   = w_end_seg && w_last && !r_loop;
   assign w_apply    = (r_state == PRIME) || (w_end_seg && !w_finish);

   // r_pf_idx is the index whose entry sits on the RAM output, ready to apply.
   assign w_pf_inc  = {1'b0, r_pf_idx} + (AW+1)'(1);
   assign w_pf_wrap = (w_pf_inc > {1'b0, r_num_m1}) ? '0 : w_pf_inc[AW-1:0];

   seg_ram #(.DEPTH(DEPTH)) u_seg_ram (
      .clk   (clk),
      .we    (w_wr_ok),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .raddr (w_rd_addr),
      .rdata (w_rd_data)
   );

   always_comb begin
      if (num_seg == '0)
         w_num_m1 = '0;
      else if (num_seg > (AW+1)'(DEPTH))
         w_num_m1 = AW'(DEPTH - 1);
      else
         w_num_m1 = AW'(num_seg - (AW+1)'(1));
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_addr   = r_pf_idx;
      case (r_state)
         IDLE: begin
            w_rd_addr = '0;
            if (w_start_ok) w_state_nxt = PRIME;
         end
         PRIME: begin
            w_rd_addr   = w_pf_wrap;
            w_state_nxt = RUN;
         end
         RUN: begin
            if (w_end_seg) begin
               w_rd_addr = w_pf_wrap;
               if (w_finish) w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_stop_ok) w_state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_num_m1   <= '0;
         r_loop     <= 1'b0;
         r_pf_idx   <= '0;
         r_cnt      <= '0;
         wave_sel   <= '0;
         amp        <= '0;
         freq       <= '0;
         duty_cycle <= DUTY_RST;
         seg_idx    <= '0;
         busy       <= 1'b0;
         seg_start  <= 1'b0;
         done       <= 1'b0;
         wr_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pf_idx  <= w_rd_addr;
         busy      <= (w_state_nxt != IDLE);
         seg_start <= 1'b0;
         done      <= 1'b0;
         wr_err    <= cfg_we && (r_state != IDLE);
         if (w_start_ok) begin
            r_num_m1 <= w_num_m1;
            r_loop   <= loop_en;
         end
         if (w_stop_ok || w_finish) begin
            amp  <= '0;
            done <= 1'b1;
         end else if (w_apply) begin
            wave_sel   <= w_rd_data.wave_sel;
            amp        <= w_rd_data.amp;
            freq       <= w_rd_data.freq;
            duty_cycle <= w_rd_data.duty;
            seg_idx    <= r_pf_idx;
            seg_start  <= 1'b1;
            r_cnt      <= DWELL_W'(dwell_load(w_rd_data.dwell));
         end else if ((r_state == RUN) && !hold && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DWELL_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wave_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wave_seq_ctrl: directed scenarios plus random traffic vs model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_wave_seq_ctrl;
   import wave_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic              clk = 1'b0;
   logic              rst, cfg_we, loop_en, start, stop, hold;
   logic [AW-1:0]     cfg_addr;
   seg_entry_t        cfg_wdata;
   logic [AW:0]       num_seg;
   logic [1:0]        wave_sel;
   logic signed [7:0] amp;
   logic [7:0]        freq, duty_cycle;
   logic [AW-1:0]     seg_idx;
   logic              busy, seg_start, done, wr_err;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   wave_seq_ctrl #(.DEPTH(DEPTH), .DWELL_W(16)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .num_seg(num_seg), .loop_en(loop_en), .start(start), .stop(stop), .hold(hold),
      .wave_sel(wave_sel), .amp(amp), .freq(freq), .duty_cycle(duty_cycle),
      .seg_idx(seg_idx), .busy(busy), .seg_start(seg_start), .done(done), .wr_err(wr_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: tracks remaining cycles of the playing segment.
   seg_entry_t        m_tab [DEPTH];
   int                m_mode = 0;     // 0 idle, 1 priming, 2 playing
   int                m_idx = 0, m_rem = 0, m_n = 1;
   bit                m_loop = 1'b0;
   logic [1:0]        e_wave;
   logic signed [7:0] e_amp;
   logic [7:0]        e_freq, e_duty;
   bit                e_busy, e_ss, e_done, e_werr;

   task automatic m_apply(input int i);
      m_idx  = i;
      e_wave = m_tab[i].wave_sel;
      e_amp  = m_tab[i].amp;
      e_freq = m_tab[i].freq;
      e_duty = m_tab[i].duty;
      m_rem  = (m_tab[i].dwell == 0) ? 1 : int'(m_tab[i].dwell);
      e_ss   = 1'b1;
   endtask

   always @(posedge clk) begin
      e_ss = 1'b0; e_done = 1'b0; e_werr = 1'b0;
      if (rst) begin
         m_mode = 0; m_idx = 0;
         e_wave = 2'd0; e_amp = 8'sd0; e_freq = 8'd0; e_duty = 8'd128;
      end else if (m_mode == 0) begin
         if (cfg_we) m_tab[cfg_addr] = cfg_wdata;
         if (start && !stop) begin
            m_mode = 1;
            m_n    = (num_seg == 0) ? 1 : ((num_seg > DEPTH) ? DEPTH : int'(num_seg));
            m_loop = loop_en;
         end
      end else begin
         e_werr = cfg_we;
         if (stop) begin
            m_mode = 0; e_amp = 8'sd0; e_done = 1'b1;
         end else if (m_mode == 1) begin
            m_apply(0); m_mode = 2;
         end else if (!hold) begin
            if (m_rem > 1)              m_rem--;
            else if (m_idx < m_n - 1)   m_apply(m_idx + 1);
            else if (m_loop)            m_apply(0);
            else begin
               m_mode = 0; e_amp = 8'sd0; e_done = 1'b1;
            end
         end
      end
      e_busy = (m_mode != 0);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("wave_sel",   32'(wave_sel),   32'(e_wave));
         chk("amp",        32'(amp),        32'(e_amp));
         chk("freq",       32'(freq),       32'(e_freq));
         chk("duty_cycle", 32'(duty_cycle), 32'(e_duty));
         chk("seg_idx",    32'(seg_idx),    32'(m_idx));
         chk("busy",       32'(busy),       32'(e_busy));
         chk("seg_start",  32'(seg_start),  32'(e_ss));
         chk("done",       32'(done),       32'(e_done));
         chk("wr_err",     32'(wr_err),     32'(e_werr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input wave_sel_e ws, input int am, input int fr,
                     input int du, input int dw);
      cfg_we = 1'b1;
      cfg_addr = AW'(a);
      cfg_wdata.wave_sel = ws;
      cfg_wdata.amp      = 8'(am);
      cfg_wdata.freq     = 8'(fr);
      cfg_wdata.duty     = 8'(du);
      cfg_wdata.dwell    = 16'(dw);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic load_t1();
      wr(0, SINE, 100, 10, 50, 4);
      wr(1, REC,  -50, 20, 60, 2);
      wr(2, SAW,   20, 30, 70, 1);
   endtask

   // Pulses start in the current cycle (cycle 0); returns in cycle 1.
   task automatic go(input int n, input bit lp);
      num_seg = 5'(n); loop_en = lp; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; num_seg = '0;
      loop_en = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
      tick(); tick();
      chk_en = 1'b1;
      chk("rst_duty", 32'(duty_cycle), 32'd128);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) wr(i, TRIA, i + 1, i, i, 1);

      // One-shot playback of three segments.
      load_t1();
      go(3, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         if (c == 1) chk("t1_prime_busy", 32'(busy), 32'd1);
         if (c == 2) chk("t1_c2_amp", 32'(amp), 32'd100);
         if (c == 2) chk("t1_c2_ss", 32'(seg_start), 32'd1);
         if (c == 5) chk("t1_c5_amp", 32'(amp), 32'd100);
         if (c == 6) chk("t1_c6_amp", 32'(amp), -32'sd50);
         if (c == 8) chk("t1_c8_idx", 32'(seg_idx), 32'd2);
         if (c == 9) chk("t1_c9_done", 32'(done), 32'd1);
         if (c == 9) chk("t1_c9_amp", 32'(amp), 32'd0);
         tick();
      end

      // Looped playback, then stop.
      go(3, 1'b1);
      for (int c = 1; c <= 13; c++) begin
         if (c == 2 || c == 6 || c == 8 || c == 9) chk("t2_ss", 32'(seg_start), 32'd1);
         if (c == 7) chk("t2_c7_ss", 32'(seg_start), 32'd0);
         if (c == 9) chk("t2_c9_amp", 32'(amp), 32'd100);
         if (c == 13) chk("t2_stop_done", 32'(done), 32'd1);
         if (c == 13) chk("t2_stop_amp", 32'(amp), 32'd0);
         if (c == 12) stop = 1'b1;
         tick();
         stop = 1'b0;
      end

      // Zero dwell: one cycle per segment.
      wr(0, SAW, 7, 1, 1, 0);
      wr(1, REC, 9, 2, 2, 0);
      go(2, 1'b1);
      tick();
      for (int c = 2; c <= 7; c++) begin
         chk("t3_ss", 32'(seg_start), 32'd1);
         chk("t3_idx", 32'(seg_idx), 32'(c % 2));
         tick();
      end
      stop = 1'b1; tick(); stop = 1'b0; tick();

      // Hold for five cycles inside a dwell-4 segment.
      wr(0, SINE, 33, 1, 1, 4);
      wr(1, REC,  44, 2, 2, 2);
      go(2, 1'b0);
      for (int c = 1; c <= 13; c++) begin
         if (c == 10) chk("t4_c10_amp", 32'(amp), 32'd33);
         if (c == 11) chk("t4_c11_amp", 32'(amp), 32'd44);
         if (c == 11) chk("t4_c11_ss", 32'(seg_start), 32'd1);
         hold = (c >= 3 && c <= 7);
         tick();
      end
      hold = 1'b0;

      // Writes while busy are dropped; start+stop together in idle does nothing.
      load_t1();
      go(3, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         if (c == 4) chk("t5_wr_err", 32'(wr_err), 32'd1);
         if (c == 3) begin
            cfg_we = 1'b1; cfg_addr = '0; cfg_wdata.amp = 8'sd99;
         end
         tick();
         cfg_we = 1'b0;
      end
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      chk("t5_ss_busy", 32'(busy), 32'd0);
      tick();
      chk("t5_ss_busy2", 32'(busy), 32'd0);
      go(1, 1'b0);
      tick();
      chk("t5_replay_amp", 32'(amp), 32'd100);
      tick(); tick(); tick(); tick(); tick();

      // Reset in the middle of playback.
      go(3, 1'b1);
      tick(); tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t6_duty", 32'(duty_cycle), 32'd128);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      go(3, 1'b0);
      tick();
      chk("t6_replay_amp", 32'(amp), 32'd100);
      for (int c = 0; c < 10; c++) tick();

      // Random traffic against the model.
      for (int k = 0; k < 4000; k++) begin
         rst      = ($urandom_range(0, 299) == 0);
         cfg_we   = ($urandom_range(0, 5) == 0);
         cfg_addr = AW'($urandom);
         cfg_wdata.wave_sel = wave_sel_e'($urandom_range(0, 3));
         cfg_wdata.amp      = 8'($urandom);
         cfg_wdata.freq     = 8'($urandom);
         cfg_wdata.duty     = 8'($urandom);
         cfg_wdata.dwell    = 16'($urandom_range(0, 5));
         start    = !cfg_we && ($urandom_range(0, 7) == 0);
         stop     = ($urandom_range(0, 59) == 0);
         hold     = ($urandom_range(0, 4) == 0);
         num_seg  = 5'($urandom);
         loop_en  = 1'($urandom);
         tick();
      end
      rst = 1'b0; cfg_we = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
